// File: rtl/ram_responder.sv
// Single-port word RAM answering the controller's RAM request bus with a fixed BUSY latency.
// Define RAM_POISON_EN to drive 32'hBAD1BAD1 on ramload whenever no read access is in progress.
module ram_responder #(
   parameter int LAT = 2,
   parameter int AW  = 12
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ramREN,
   input  logic        ramWEN,
   input  logic [31:0] ramaddr,
   input  logic [31:0] ramstore,
   output logic [1:0]  ramstate,
   output logic [31:0] ramload
);

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   localparam logic [3:0] CNT_INIT = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

`ifdef RAM_POISON_EN
   localparam logic [31:0] IDLE_LOAD = 32'hBAD1BAD1;
`else
   localparam logic [31:0] IDLE_LOAD = 32'h0;
`endif

   ramstate_t        r_state;
   logic             r_op;
   logic [AW-1:0]    r_waddr;
   logic [3:0]       r_cnt;
   logic [31:0]      r_mem [2**AW];

   ramstate_t        w_next_state;
   logic             w_next_op;
   logic [AW-1:0]    w_next_waddr;
   logic [3:0]       w_next_cnt;
   logic             w_new;
   logic             w_any;
   logic             w_hi_bad;
   logic             w_illegal;
   logic             w_legal;
   logic [AW-1:0]    w_addr;
   logic             w_unused_lsb;

   assign w_any        = ramREN | ramWEN;
   assign w_hi_bad     = |ramaddr[31:AW+2];
   assign w_illegal    = (ramREN & ramWEN) | (w_any & w_hi_bad);
   assign w_legal      = w_any & ~w_illegal;
   assign w_addr       = ramaddr[AW+1:2];
   assign w_unused_lsb = ^ramaddr[1:0];

   always_comb begin
      w_next_state = r_state;
      w_next_op    = r_op;
      w_next_waddr = r_waddr;
      w_next_cnt   = r_cnt;
      w_new        = 1'b0;
      case (r_state)
         BUSY: begin
            if (!w_any)
               w_next_state = FREE;
            else if (w_illegal)
               w_next_state = ERROR;
            else if ((ramWEN != r_op) || (w_addr != r_waddr))
               w_new = 1'b1;
            else if (r_cnt == 4'd0)
               w_next_state = ACCESS;
            else
               w_next_cnt = r_cnt - 4'd1;
         end
         // FREE, ACCESS and ERROR all treat a held request as a fresh transaction
         default: begin
            if (w_illegal)
               w_next_state = ERROR;
            else if (w_legal)
               w_new = 1'b1;
            else
               w_next_state = FREE;
         end
      endcase
      if (w_new) begin
         w_next_op    = ramWEN;
         w_next_waddr = w_addr;
         w_next_cnt   = CNT_INIT;
         w_next_state = (LAT > 0) ? BUSY : ACCESS;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= FREE;
         r_op    <= 1'b0;
         r_waddr <= '0;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_next_state;
         r_op    <= w_next_op;
         r_waddr <= w_next_waddr;
         r_cnt   <= w_next_cnt;
      end
   end

   // Storage is intentionally not reset; a write commits with the live data at the ACCESS edge
   always_ff @(posedge CLK) begin
      if (r_state == ACCESS && r_op)
         r_mem[r_waddr] <= ramstore;
   end

   assign ramstate = r_state;
   assign ramload  = (r_state == ACCESS && !r_op) ? r_mem[r_waddr] : IDLE_LOAD;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboarded bench for ram_responder: one LAT=2 instance and one LAT=0 instance share the request bus.
module tb_ram_responder;

`ifdef RAM_POISON_EN
   localparam logic [31:0] IDLE = 32'hBAD1BAD1;
`else
   localparam logic [31:0] IDLE = 32'h0;
`endif

   localparam logic [1:0] S_FREE   = 2'd0;
   localparam logic [1:0] S_BUSY   = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_ERROR  = 2'd3;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        ren;
   logic        wen;
   logic [31:0] addr;
   logic [31:0] store;
   logic [1:0]  st_a;
   logic [1:0]  st_b;
   logic [31:0] ld_a;
   logic [31:0] ld_b;

   always #5 CLK = ~CLK;

   ram_responder #(.LAT(2), .AW(12)) u_a (
      .CLK(CLK), .nRST(nRST), .ramREN(ren), .ramWEN(wen),
      .ramaddr(addr), .ramstore(store), .ramstate(st_a), .ramload(ld_a)
   );

   ram_responder #(.LAT(0), .AW(12)) u_b (
      .CLK(CLK), .nRST(nRST), .ramREN(ren), .ramWEN(wen),
      .ramaddr(addr), .ramstore(store), .ramstate(st_b), .ramload(ld_b)
   );

   typedef struct {
      bit          dut;
      logic [1:0]  st;
      logic [31:0] ld;
      string       tag;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Drive one cycle of inputs and queue what the selected DUT must show in that cycle
   task automatic c(input bit d, input logic rn, input logic r, input logic w,
                    input logic [31:0] a, input logic [31:0] s,
                    input logic [1:0] st, input logic [31:0] ld, input string tag);
      exp_t e;
      nRST  = rn;
      ren   = r;
      wen   = w;
      addr  = a;
      store = s;
      e.dut = d;
      e.st  = st;
      e.ld  = ld;
      e.tag = tag;
      q.push_back(e);
      @(posedge CLK);
      #1;
   endtask

   // Full LAT=2 transaction from FREE, request held through ACCESS, then released
   task automatic txn(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] s, input logic [31:0] ld, input string tag);
      c(0, 1, r, w, a, s, S_FREE,   IDLE, tag);
      c(0, 1, r, w, a, s, S_BUSY,   IDLE, tag);
      c(0, 1, r, w, a, s, S_BUSY,   IDLE, tag);
      c(0, 1, r, w, a, s, S_ACCESS, r ? ld : IDLE, tag);
      c(0, 1, 0, 0, a, s, S_BUSY,   IDLE, tag);
   endtask

   always @(negedge CLK) begin
      exp_t        e;
      logic [1:0]  gs;
      logic [31:0] gl;
      if (q.size() > 0) begin
         e  = q.pop_front();
         gs = e.dut ? st_b : st_a;
         gl = e.dut ? ld_b : ld_a;
         n_vec++;
         if (gs !== e.st) begin
            n_err++;
            $display("FAIL %s ramstate: got %0d want %0d", e.tag, gs, e.st);
         end
         n_vec++;
         if (gl !== e.ld) begin
            n_err++;
            $display("FAIL %s ramload: got %h want %h", e.tag, gl, e.ld);
         end
      end
   end

   initial begin
      nRST  = 1'b0;
      ren   = 1'b0;
      wen   = 1'b0;
      addr  = '0;
      store = '0;
      @(posedge CLK);
      #1;

      c(0, 0, 0, 0, 32'h0, 32'h0, S_FREE, IDLE, "reset");
      c(0, 0, 0, 0, 32'h0, 32'h0, S_FREE, IDLE, "reset");

      txn(0, 1, 32'h40, 32'hDEADBEEF, 32'h0, "wr40");
      txn(1, 0, 32'h40, 32'h0, 32'hDEADBEEF, "rd40");

      txn(0, 1, 32'h44, 32'h44444444, 32'h0, "wr44");
      c(0, 1, 1, 0, 32'h40, 32'h0, S_FREE,   IDLE, "restart");
      c(0, 1, 1, 0, 32'h40, 32'h0, S_BUSY,   IDLE, "restart");
      c(0, 1, 1, 0, 32'h44, 32'h0, S_BUSY,   IDLE, "restart");
      c(0, 1, 1, 0, 32'h44, 32'h0, S_BUSY,   IDLE, "restart");
      c(0, 1, 1, 0, 32'h44, 32'h0, S_BUSY,   IDLE, "restart");
      c(0, 1, 1, 0, 32'h44, 32'h0, S_ACCESS, 32'h44444444, "restart");
      c(0, 1, 0, 0, 32'h44, 32'h0, S_BUSY,   IDLE, "restart");

      txn(0, 1, 32'h10, 32'h11112222, 32'h0, "wr10");
      c(0, 1, 1, 1, 32'h10, 32'h99999999, S_FREE,   IDLE, "both");
      c(0, 1, 1, 1, 32'h10, 32'h99999999, S_ERROR,  IDLE, "both");
      c(0, 1, 1, 1, 32'h10, 32'h99999999, S_ERROR,  IDLE, "both");
      c(0, 1, 1, 0, 32'h10, 32'h99999999, S_ERROR,  IDLE, "both_drop");
      c(0, 1, 1, 0, 32'h10, 32'h99999999, S_BUSY,   IDLE, "both_drop");
      c(0, 1, 1, 0, 32'h10, 32'h99999999, S_BUSY,   IDLE, "both_drop");
      c(0, 1, 1, 0, 32'h10, 32'h99999999, S_ACCESS, 32'h11112222, "both_drop");
      c(0, 1, 0, 0, 32'h10, 32'h99999999, S_BUSY,   IDLE, "both_drop");

      txn(0, 1, 32'h3FFC, 32'h0FFC0FFC, 32'h0, "wr3ffc");
      c(0, 1, 1, 0, 32'h4000, 32'h0, S_FREE,  IDLE, "range");
      c(0, 1, 1, 0, 32'h4000, 32'h0, S_ERROR, IDLE, "range");
      c(0, 1, 0, 0, 32'h4000, 32'h0, S_ERROR, IDLE, "range");
      c(0, 1, 0, 0, 32'h4000, 32'h0, S_FREE,  IDLE, "range");
      txn(1, 0, 32'h3FFC, 32'h0, 32'h0FFC0FFC, "rd3ffc");

      txn(0, 1, 32'h80, 32'hCAFEF00D, 32'h0, "wr80");
      c(0, 1, 0, 1, 32'h80, 32'h12345678, S_FREE, IDLE, "rst_mid");
      c(0, 1, 0, 1, 32'h80, 32'h12345678, S_BUSY, IDLE, "rst_mid");
      c(0, 0, 0, 1, 32'h80, 32'h12345678, S_FREE, IDLE, "rst_mid");
      c(0, 0, 0, 1, 32'h80, 32'h12345678, S_FREE, IDLE, "rst_mid");
      c(0, 1, 0, 0, 32'h80, 32'h0,        S_FREE, IDLE, "rst_mid");
      txn(1, 0, 32'h80, 32'h0, 32'hCAFEF00D, "rd80");

      c(1, 0, 0, 0, 32'h0, 32'h0, S_FREE, IDLE, "lat0_rst");
      c(1, 1, 0, 1, 32'h0, 32'hA5A50001, S_FREE,   IDLE, "lat0_w0");
      c(1, 1, 0, 1, 32'h0, 32'hA5A50001, S_ACCESS, IDLE, "lat0_w0");
      c(1, 1, 0, 0, 32'h0, 32'hA5A50001, S_ACCESS, IDLE, "lat0_w0");
      c(1, 1, 0, 1, 32'h4, 32'h5A5A0004, S_FREE,   IDLE, "lat0_w4");
      c(1, 1, 0, 1, 32'h4, 32'h5A5A0004, S_ACCESS, IDLE, "lat0_w4");
      c(1, 1, 0, 0, 32'h4, 32'h5A5A0004, S_ACCESS, IDLE, "lat0_w4");
      c(1, 1, 1, 0, 32'h0, 32'h0, S_FREE,   IDLE,         "lat0_rd");
      c(1, 1, 1, 0, 32'h4, 32'h0, S_ACCESS, 32'hA5A50001, "lat0_rd");
      c(1, 1, 1, 0, 32'h4, 32'h0, S_ACCESS, 32'h5A5A0004, "lat0_rd");
      c(1, 1, 0, 0, 32'h4, 32'h0, S_ACCESS, 32'h5A5A0004, "lat0_rd");
      c(1, 1, 0, 0, 32'h4, 32'h0, S_FREE,   IDLE,         "lat0_rd");

      @(negedge CLK);
      @(negedge CLK);
      n_vec++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
